// File: rtl/seg_display_driver.sv
// Purpose: multiplexes a 4-digit mm:ss stopwatch value onto a common-anode 7-segment display, with adjust-mode blinking.
// Latency: an/seg/dp are registered, one clk after the scan/blink/snapshot state and adj/sel they depend on.
// Backpressure: none; free-running scan with no handshake, and digit inputs are sampled once per scan frame.
module seg_display_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] m10,
  input  logic [3:0] m1,
  input  logic [2:0] s10,
  input  logic [3:0] s1,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_MAX   = BLK_W'(BLINK_DIV - 1);

  typedef struct packed {
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
  } digits_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             phase_q, phase_d;
  digits_t          snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       cnt_wrap;
  logic       blk_wrap;
  logic [3:0] digit;
  logic [6:0] decoded;
  logic       blank;

  // Scan counter, digit index, blink phase and frame snapshot next-state.
  // The snapshot is only reloaded as idx wraps 3->0, so a whole frame shows one coherent time.
  always_comb begin
    cnt_wrap = (cnt_q == CNT_MAX);
    blk_wrap = (blk_q == BLK_MAX);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
    blk_d    = blk_wrap ? '0 : blk_q + BLK_W'(1);
    phase_d  = blk_wrap ? ~phase_q : phase_q;
    snap_d   = snap_q;
    if (cnt_wrap && (idx_q == 2'd3)) begin
      snap_d = '{m10: m10, m1: m1, s10: s10, s1: s1};
    end
  end

  // Pick the digit for the current slot, decode it, and apply slot-start and blink blanking.
  // adj/sel are used live so an adjust-mode change shows on the very next output update.
  always_comb begin
    digit = 4'd0;
    case (idx_q)
      2'd0: digit = snap_q.s1;
      2'd1: digit = {1'b0, snap_q.s10};
      2'd2: digit = snap_q.m1;
      2'd3: digit = {1'b0, snap_q.m10};
      default: digit = 4'd0;
    endcase

    decoded = 7'b0111111;
    case (digit)
      4'd0: decoded = 7'b1000000;
      4'd1: decoded = 7'b1111001;
      4'd2: decoded = 7'b0100100;
      4'd3: decoded = 7'b0110000;
      4'd4: decoded = 7'b0011001;
      4'd5: decoded = 7'b0010010;
      4'd6: decoded = 7'b0000010;
      4'd7: decoded = 7'b1111000;
      4'd8: decoded = 7'b0000000;
      4'd9: decoded = 7'b0010000;
      default: decoded = 7'b0111111;
    endcase

    // idx[1] distinguishes the minutes pair (1) from the seconds pair (0).
    blank = (cnt_q < BLANK_END) || (adj && !phase_q && (idx_q[1] == ~sel));

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decoded;
      dp_d  = (idx_q != 2'd2);
    end
  end

  // State and output registers; reset blanks the display immediately without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      blk_q   <= '0;
      phase_q <= 1'b1;
      snap_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Purpose: directed, table-driven check of seg_display_driver scan, decode, snapshot, blink and reset.
// Latency: outputs sampled 1 time unit after each rising edge; cyc counts edges since reset release.
// Backpressure: not applicable; a negedge monitor checks anode one-hot and blank consistency every cycle.
module tb_seg_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] m10 = 3'd0;
  logic [3:0] m1  = 4'd0;
  logic [2:0] s10 = 3'd0;
  logic [3:0] s1  = 4'd0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg_display_driver #(
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2),
    .BLINK_DIV   (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m10(m10),
    .m1 (m1),
    .s10(s10),
    .s1 (s1),
    .adj(adj),
    .sel(sel),
    .an (an),
    .seg(seg),
    .dp (dp)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_0   = 7'b1000000;

  typedef struct {
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
    logic [6:0] seg0;  // s1 slot, an=1110
    logic [6:0] seg1;  // s10 slot, an=1101
    logic [6:0] seg2;  // m1 slot, an=1011
    logic [6:0] seg3;  // m10 slot, an=0111
  } vec_t;

  vec_t vecs [6];

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  mon_en   = 1'b0;

  // Output index n reflecting scan position (frame, slot, cnt) with 8-cycle slots.
  function automatic int at(input int frame, input int slot, input int c);
    return 32 * frame + 8 * slot + c + 1;
  endfunction

  function automatic logic [3:0] an_of(input int slot);
    case (slot)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int n);
    if (n < cyc) begin
      failures++;
      $display("FAIL schedule: cyc=%0d already past target %0d", cyc, n);
    end
    while (cyc < n) step();
  endtask

  task automatic chk(input string name, input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
    checks++;
    if (an !== ean || seg !== eseg || dp !== edp) begin
      failures++;
      $display("FAIL %s (cyc=%0d): got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, cyc, an, seg, dp, ean, eseg, edp);
    end
  endtask

  // Every cycle: at most one anode active, and a dark display carries dark cathodes and dp.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(~an) > 1 || (an == AN_OFF && (seg != SEG_OFF || dp != 1'b1))) begin
        failures++;
        $display("FAIL monitor (t=%0t): an=%b seg=%b dp=%b", $time, an, seg, dp);
      end
    end
  end

  initial begin
    logic [6:0] eseg;

    vecs[0] = '{3'd5, 4'd9,  3'd4, 4'd7,  7'b1111000, 7'b0011001, 7'b0010000, 7'b0010010};
    vecs[1] = '{3'd0, 4'd1,  3'd2, 4'd3,  7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
    vecs[2] = '{3'd6, 4'd8,  3'd7, 4'd6,  7'b0000010, 7'b1111000, 7'b0000000, 7'b0000010};
    vecs[3] = '{3'd3, 4'd12, 3'd5, 4'd15, 7'b0111111, 7'b0010010, 7'b0111111, 7'b0110000};
    vecs[4] = '{3'd1, 4'd10, 3'd0, 4'd9,  7'b0010000, 7'b1000000, 7'b0111111, 7'b1111001};
    vecs[5] = '{3'd2, 4'd4,  3'd3, 4'd11, 7'b0111111, 7'b0110000, 7'b0011001, 7'b0100100};

    // Held in reset with live inputs: display stays dark.
    m10 = 3'd5; m1 = 4'd9; s10 = 3'd4; s1 = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dark", AN_OFF, SEG_OFF, 1'b1);
    mon_en = 1'b1;

    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    // First frame after reset: snapshot still zero, two blank cycles per slot.
    run_to(at(0, 0, 0)); chk("f0_blank_c0", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(0, 0, 1)); chk("f0_blank_c1", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(0, 0, 2)); chk("f0_s1_zero", 4'b1110, SEG_0, 1'b1);
    run_to(at(0, 1, 4)); chk("f0_s10_zero", 4'b1101, SEG_0, 1'b1);
    run_to(at(0, 2, 4)); chk("f0_m1_zero", 4'b1011, SEG_0, 1'b0);
    run_to(at(0, 3, 4)); chk("f0_m10_zero", 4'b0111, SEG_0, 1'b1);

    // Decode table: inputs applied during frame k, displayed during frame k+1.
    for (int k = 0; k < 6; k++) begin
      m10 = vecs[k].m10; m1 = vecs[k].m1; s10 = vecs[k].s10; s1 = vecs[k].s1;
      for (int slot = 0; slot < 4; slot++) begin
        case (slot)
          0:       eseg = vecs[k].seg0;
          1:       eseg = vecs[k].seg1;
          2:       eseg = vecs[k].seg2;
          default: eseg = vecs[k].seg3;
        endcase
        run_to(at(k + 1, slot, 1));
        chk($sformatf("vec%0d_slot%0d_blank", k, slot), AN_OFF, SEG_OFF, 1'b1);
        run_to(at(k + 1, slot, 4));
        chk($sformatf("vec%0d_slot%0d", k, slot), an_of(slot), eseg, (slot == 2) ? 1'b0 : 1'b1);
      end
    end

    // Mid-frame input change must not tear the frame being shown.
    m10 = 3'd1; m1 = 4'd2; s10 = 3'd3; s1 = 4'd3;
    run_to(at(7, 0, 4)); chk("snap_s1_3", 4'b1110, 7'b0110000, 1'b1);
    run_to(at(7, 1, 2));
    s1 = 4'd8; m1 = 4'd5;
    run_to(at(7, 2, 4)); chk("snap_m1_held", 4'b1011, 7'b0100100, 1'b0);
    run_to(at(8, 0, 4)); chk("snap_s1_8", 4'b1110, 7'b0000000, 1'b1);
    run_to(at(8, 2, 4)); chk("snap_m1_5", 4'b1011, 7'b0010010, 1'b0);

    // Blinking seconds pair: phase is visible for outputs 1..64, dark 65..128, and so on.
    adj = 1'b1; sel = 1'b1;
    run_to(at(9, 0, 4));  chk("blk_sec_vis", 4'b1110, 7'b0000000, 1'b1);
    run_to(at(10, 0, 4)); chk("blk_sec_s1_off", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(10, 1, 4)); chk("blk_sec_s10_off", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(10, 2, 4)); chk("blk_sec_m1_on", 4'b1011, 7'b0010010, 1'b0);
    run_to(at(10, 3, 4)); chk("blk_sec_m10_on", 4'b0111, 7'b1111001, 1'b1);
    run_to(at(11, 0, 4)); chk("blk_sec_s1_off2", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(12, 0, 4)); chk("blk_sec_s1_back", 4'b1110, 7'b0000000, 1'b1);

    // Blinking moves to the minutes pair.
    sel = 1'b0;
    run_to(at(14, 0, 4)); chk("blk_min_s1_on", 4'b1110, 7'b0000000, 1'b1);
    run_to(at(14, 2, 4)); chk("blk_min_m1_off", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(14, 3, 4)); chk("blk_min_m10_off", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(15, 2, 4)); chk("blk_min_m1_off2", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(16, 2, 4)); chk("blk_min_m1_back", 4'b1011, 7'b0010010, 1'b0);

    // adj is live: dropping it mid dark phase restores the slot on the next update.
    run_to(at(18, 2, 4)); chk("adj_live_before", AN_OFF, SEG_OFF, 1'b1);
    adj = 1'b0;
    step();               chk("adj_live_after", 4'b1011, 7'b0010010, 1'b0);

    // Asynchronous reset mid-slot, then restart from zeroed counters and snapshot.
    run_to(at(19, 1, 4)); chk("pre_reset_s10", 4'b1101, 7'b0110000, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", AN_OFF, SEG_OFF, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    run_to(at(0, 0, 0)); chk("rst2_blank_c0", AN_OFF, SEG_OFF, 1'b1);
    run_to(at(0, 0, 2)); chk("rst2_s1_zero", 4'b1110, SEG_0, 1'b1);
    run_to(at(0, 2, 4)); chk("rst2_m1_zero", 4'b1011, SEG_0, 1'b0);
    run_to(at(1, 0, 4)); chk("rst2_s1_8", 4'b1110, 7'b0000000, 1'b1);

    // Blink phase restarted at reset: frame 1 visible, frame 2 dark.
    adj = 1'b1; sel = 1'b1;
    run_to(at(1, 1, 4)); chk("rst2_blk_vis", 4'b1101, 7'b0110000, 1'b1);
    run_to(at(2, 0, 4)); chk("rst2_blk_off", AN_OFF, SEG_OFF, 1'b1);
    adj = 1'b0;

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
